operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Issue-side stage directly upstream of register_file.
- Accepts one decoded instruction at a time and checks source/destination registers against a pending-write scoreboard.
- Drives register_file read ports, captures the two 64-bit operands, and presents them with control to the execute stage over valid/ready.
- Snoops the register_file write port (writeback) to clear scoreboard entries.

Parameters:
- NUM_REGS, 16, architectural registers (matches register_file).
- ADDR_W, 4, register address width = clog2(NUM_REGS).
- DATA_W, 64, operand/register width.
- CTRL_W, 8, opaque control payload carried issue -> execute.

Ports:
- clk  in  1  system clock, all state rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction present.
- issue_ready  out  1  stage can accept; high only in IDLE.
- issue_rs0, issue_rs1  in  ADDR_W  source registers.
- issue_use  in  2  bit0 = rs0 used, bit1 = rs1 used.
- issue_rd  in  ADDR_W  destination register.
- issue_wr  in  1  instruction writes rd.
- issue_ctrl  in  CTRL_W  payload.
- rf_read_en  out  2  per-port read enable to register_file.
- rf_raddr_0, rf_raddr_1  out  ADDR_W  read addresses.
- rf_rdata_0, rf_rdata_1  in  DATA_W  read data, valid the cycle after rf_read_en.
- wb_valid  in  1  writeback (same signal as register_file write_en).
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- op_valid  out  1  operands ready for execute.
- op_ready  in  1  execute accepts.
- op_a, op_b  out  DATA_W  operands; 0 for unused sources.
- op_rd  out  ADDR_W  destination.
- op_wr  out  1  destination write flag.
- op_ctrl  out  CTRL_W  payload.
- busy_pending  out  NUM_REGS  scoreboard vector, for debug.

Behaviour:
- Reset (asynchronous): state IDLE, scoreboard all 0, op_valid 0, op_a/op_b/op_rd/op_ctrl 0, op_wr 0, rf_read_en 0, rf_raddr_* 0. issue_ready = 1 once reset_n deasserts.
- States: IDLE, CHECK, READ, HOLD.
- IDLE: issue_ready = 1. On issue_valid && issue_ready, latch rs0/rs1/use/rd/wr/ctrl and go to CHECK.
- CHECK: hazard = (use[0] && pending[rs0]) || (use[1] && pending[rs1]) || (wr && pending[rd]).
  - If hazard, stay in CHECK with rf_read_en = 0.
  - If no hazard, rf_read_en = use, rf_raddr_* = latched rs0/rs1 (combinational), go to READ.
- READ: capture rf_rdata_0/1 into op_a/op_b; unused source captures 0. Go to HOLD with op_valid = 1 next cycle.
- HOLD: op_valid = 1; all op_* outputs stable until op_ready.
  - On op_valid && op_ready: if op_wr, set pending[op_rd]; return to IDLE.
- Minimum latency: issue accept at cycle T, op_valid at T+3. Throughput: one instruction per 4 cycles minimum.
- Scoreboard:
  - Set on dispatch as above; clear on wb_valid for wb_addr.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
- Pending bits are registered. A clear becomes visible to CHECK the following cycle, so an RF read never coincides with a writeback to the same register.
- wb_valid to a non-pending register is legal and does not change the scoreboard.
- reset_n asserted mid-operation: instruction discarded, scoreboard cleared. No outputs glitch high after deassertion.

Optional Feature:
- Macro: OPERAND_COLLECTOR_WB_BYPASS_EN.
- Defined: in CHECK, when wb_valid && wb_addr matches a used, pending source, wb_data is captured directly into the operand register for that source and that source is marked satisfied. Only unsatisfied sources are read from the RF.
  - When the last blocking hazard is resolved this way, the transition to READ happens in the same cycle, saving one cycle versus no bypass.
  - A WAW hazard on rd still waits for the registered clear.
- Not defined: no bypass; hazards resolve only via the registered scoreboard clear.

Decomposition:
- Package harmonica_rf_pkg:
  - NUM_REGS, ADDR_W, DATA_W constants.
  - oc_state_t enum {IDLE, CHECK, READ, HOLD}.
  - issue_pkt_t struct {rs0, rs1, use, rd, wr, ctrl}.
- Sub-module rf_scoreboard:
  - Pending vector with set/clear ports and set-wins rule.
  - Combinational lookup for three addresses returning a hazard bit.

Test Plan:
- Reset mid-HOLD with op_valid = 1 -> op_valid 0, busy_pending 16'h0000, issue_ready 1 after deassert.
- R3 preloaded 64'hDEAD_BEEF, R5 = 64'h1234; issue rs0 = 3, rs1 = 5, use 2'b11, accepted at T, op_ready = 1 -> op_valid at T+3 with op_a = 64'hDEAD_BEEF, op_b = 64'h1234.
- Dispatch writer rd = 7, then issue rs0 = 7 -> stalls in CHECK, rf_read_en 0. wb_valid, wb_addr = 7, wb_data = 64'hAA at cycle W -> rf_read_en at W+1, op_a = 64'hAA at W+3. With OPERAND_COLLECTOR_WB_BYPASS_EN, op_a = 64'hAA is captured at W and op_valid is one cycle earlier.
- op_ready held 0 for 5 cycles in HOLD -> op_* stable, issue_ready 0, next issue accepted only after the handshake.
- Same-cycle dispatch of a writer to rd = 2 and wb_valid to addr 2 -> busy_pending[2] = 1.
- use = 2'b00 -> rf_read_en never asserted, op_a = op_b = 0.

Source files
------------

// File: rtl/harmonica_rf_pkg.sv
// Shared constants and types for the register-file issue path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package harmonica_rf_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 64;
  localparam int CTRL_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } oc_state_t;

  // Decoded instruction as latched by the operand collector.
  typedef struct packed {
    logic [ADDR_W-1:0] rs0;
    logic [ADDR_W-1:0] rs1;
    logic [1:0]        use_mask;  // bit0 = rs0 used, bit1 = rs1 used
    logic [ADDR_W-1:0] rd;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } issue_pkt_t;

  // One-hot register mask, all zero when en is low.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a,
                                                      input logic              en);
    addr_onehot = en ? (NUM_REGS'(1) << a) : '0;
  endfunction

endpackage

// File: rtl/operand_collector_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on dispatch, cleared on writeback.
// Latency: set/clear registered (visible next cycle); hazard lookup is combinational.
// Backpressure: none; set and clear of the same register in one cycle leaves the bit set.
// Ports: clk, reset_n (async active-low); i_set_vld/i_set_addr; i_clr_vld/i_clr_addr;
//        i_chk_en[2:0] enables lookups of i_chk_rs0/i_chk_rs1/i_chk_rd; o_hazard; o_pending.
module rf_scoreboard
  import harmonica_rf_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_set_vld,
  input  logic [ADDR_W-1:0]   i_set_addr,
  input  logic                i_clr_vld,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  input  logic [2:0]          i_chk_en,
  input  logic [ADDR_W-1:0]   i_chk_rs0,
  input  logic [ADDR_W-1:0]   i_chk_rs1,
  input  logic [ADDR_W-1:0]   i_chk_rd,
  output logic                o_hazard,
  output logic [NUM_REGS-1:0] o_pending
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  assign w_set_mask = addr_onehot(i_set_addr, i_set_vld);
  assign w_clr_mask = addr_onehot(i_clr_addr, i_clr_vld);

  // Clear is applied before set so a simultaneous set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_hazard = (i_chk_en[0] && r_pending[i_chk_rs0]) ||
                    (i_chk_en[1] && r_pending[i_chk_rs1]) ||
                    (i_chk_en[2] && r_pending[i_chk_rd]);

  assign o_pending = r_pending;

endmodule

// File: rtl/operand_collector.sv
// Operand collector: hazard-checks one instruction, reads register_file, hands operands to execute.
// Latency: issue accept at T -> op_valid at T+3 when hazard-free; one instruction per 4 cycles.
// Backpressure: issue_ready only in IDLE; op_* held stable in HOLD until op_ready.
// Ports: clk, reset_n; issue_* (valid/ready in); rf_read_en/rf_raddr_*/rf_rdata_* (RF read);
//        wb_* (writeback snoop); op_* (valid/ready out); busy_pending (scoreboard debug view).
// Build option: OPERAND_COLLECTOR_WB_BYPASS_EN forwards wb_data into a stalled source operand.
module operand_collector
  import harmonica_rf_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rs0,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [1:0]          issue_use,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_wr,
  input  logic [CTRL_W-1:0]   issue_ctrl,
  output logic [1:0]          rf_read_en,
  output logic [ADDR_W-1:0]   rf_raddr_0,
  output logic [ADDR_W-1:0]   rf_raddr_1,
  input  logic [DATA_W-1:0]   rf_rdata_0,
  input  logic [DATA_W-1:0]   rf_rdata_1,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [ADDR_W-1:0]   op_rd,
  output logic                op_wr,
  output logic [CTRL_W-1:0]   op_ctrl,
  output logic [NUM_REGS-1:0] busy_pending
);

  oc_state_t           r_state;
  oc_state_t           w_next_state;
  issue_pkt_t          r_pkt;
  issue_pkt_t          w_issue_pkt;
  logic [1:0]          r_sat;      // source already forwarded from writeback
  logic [1:0]          w_byp;      // source forwarded this cycle
  logic [1:0]          w_need;     // sources still to be checked and read from the RF
  logic                w_hazard;
  logic [NUM_REGS-1:0] w_pending;
  logic                w_dispatch;

  assign w_issue_pkt = '{rs0: issue_rs0, rs1: issue_rs1, use_mask: issue_use,
                         rd: issue_rd, wr: issue_wr, ctrl: issue_ctrl};

`ifdef OPERAND_COLLECTOR_WB_BYPASS_EN
  // Forward only into a used, still-unsatisfied source that the scoreboard marks pending.
  assign w_byp[0] = (r_state == CHECK) && wb_valid && r_pkt.use_mask[0] && !r_sat[0] &&
                    w_pending[r_pkt.rs0] && (wb_addr == r_pkt.rs0);
  assign w_byp[1] = (r_state == CHECK) && wb_valid && r_pkt.use_mask[1] && !r_sat[1] &&
                    w_pending[r_pkt.rs1] && (wb_addr == r_pkt.rs1);
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_data;
  assign w_byp            = 2'b00;
`endif

  assign w_need     = r_pkt.use_mask & ~r_sat & ~w_byp;
  assign w_dispatch = op_valid && op_ready && op_wr;

  // rd is always checked when written: a WAW hazard waits for the registered clear.
  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_set_vld  (w_dispatch),
    .i_set_addr (op_rd),
    .i_clr_vld  (wb_valid),
    .i_clr_addr (wb_addr),
    .i_chk_en   ({r_pkt.wr, w_need}),
    .i_chk_rs0  (r_pkt.rs0),
    .i_chk_rs1  (r_pkt.rs1),
    .i_chk_rd   (r_pkt.rd),
    .o_hazard   (w_hazard),
    .o_pending  (w_pending)
  );

  assign busy_pending = w_pending;
  assign rf_raddr_0   = r_pkt.rs0;
  assign rf_raddr_1   = r_pkt.rs1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    issue_ready  = 1'b0;
    rf_read_en   = 2'b00;
    op_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) w_next_state = CHECK;
      end
      CHECK: begin
        if (!w_hazard) begin
          rf_read_en   = w_need;
          w_next_state = READ;
        end
      end
      READ: begin
        w_next_state = HOLD;
      end
      HOLD: begin
        op_valid = 1'b1;
        if (op_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt   <= '0;
      r_sat   <= 2'b00;
      op_a    <= '0;
      op_b    <= '0;
      op_rd   <= '0;
      op_wr   <= 1'b0;
      op_ctrl <= '0;
    end else begin
      if (r_state == IDLE && issue_valid) begin
        r_pkt <= w_issue_pkt;
        r_sat <= 2'b00;
      end
      if (r_state == CHECK) r_sat <= r_sat | w_byp;
      if (w_byp[0]) op_a <= wb_data;
      if (w_byp[1]) op_b <= wb_data;
      if (r_state == READ) begin
        // Forwarded sources keep their captured value; unused sources read as zero.
        if (!r_sat[0]) op_a <= r_pkt.use_mask[0] ? rf_rdata_0 : '0;
        if (!r_sat[1]) op_b <= r_pkt.use_mask[1] ? rf_rdata_1 : '0;
        op_rd   <= r_pkt.rd;
        op_wr   <= r_pkt.wr;
        op_ctrl <= r_pkt.ctrl;
      end
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a small register-file model and an output scoreboard.
module tb_operand_collector;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_rs0;
  logic [3:0]  issue_rs1;
  logic [1:0]  issue_use;
  logic [3:0]  issue_rd;
  logic        issue_wr;
  logic [7:0]  issue_ctrl;
  logic [1:0]  rf_read_en;
  logic [3:0]  rf_raddr_0;
  logic [3:0]  rf_raddr_1;
  logic [63:0] rf_rdata_0;
  logic [63:0] rf_rdata_1;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [63:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [3:0]  op_rd;
  logic        op_wr;
  logic [7:0]  op_ctrl;
  logic [15:0] busy_pending;

  operand_collector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rs0    (issue_rs0),
    .issue_rs1    (issue_rs1),
    .issue_use    (issue_use),
    .issue_rd     (issue_rd),
    .issue_wr     (issue_wr),
    .issue_ctrl   (issue_ctrl),
    .rf_read_en   (rf_read_en),
    .rf_raddr_0   (rf_raddr_0),
    .rf_raddr_1   (rf_raddr_1),
    .rf_rdata_0   (rf_rdata_0),
    .rf_rdata_1   (rf_rdata_1),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .op_wr        (op_wr),
    .op_ctrl      (op_ctrl),
    .busy_pending (busy_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: synchronous write, read data valid the cycle after read enable.
  logic [63:0] rf_mem [16];
  always @(posedge clk) begin
    if (wb_valid) rf_mem[wb_addr] <= wb_data;
    if (rf_read_en[0]) rf_rdata_0 <= rf_mem[rf_raddr_0];
    if (rf_read_en[1]) rf_rdata_1 <= rf_mem[rf_raddr_1];
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  rd;
    logic        wr;
    logic [7:0]  ctrl;
    int          vcyc;
  } want_t;

  want_t want_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_want(input logic [63:0] a, input logic [63:0] b, input logic [3:0] rd,
                           input logic wr, input logic [7:0] ctrl, input int vcyc);
    want_t w;
    w.a = a; w.b = b; w.rd = rd; w.wr = wr; w.ctrl = ctrl; w.vcyc = vcyc;
    want_q.push_back(w);
  endtask

  // Called at a negedge. Returns t = cycle index whose closing edge accepts the instruction,
  // and returns at the following negedge (the CHECK cycle when accepted at t).
  task automatic do_issue(input logic [3:0] rs0, input logic [3:0] rs1, input logic [1:0] use_m,
                          input logic [3:0] rd, input logic wr, input logic [7:0] ctrl,
                          output int t);
    int n;
    n = 0;
    issue_valid = 1'b1;
    issue_rs0 = rs0; issue_rs1 = rs1; issue_use = use_m;
    issue_rd = rd; issue_wr = wr; issue_ctrl = ctrl;
    while (!issue_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: issue_ready stayed 0, expected 1 within 50 cycles");
    end
    t = cyc;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((want_q.size() != 0 || op_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d outstanding, expected 0", want_q.size());
    end
  endtask

  // Monitor: compares every handshake against the head of the expected queue.
  logic prev_v    = 1'b0;
  int   first_cyc = 0;
  always begin
    want_t w;
    @(negedge clk);
    #1;
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (op_valid && !prev_v) first_cyc = cyc;
      prev_v = op_valid;
      if (op_valid && op_ready) begin
        if (want_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_op: handshake with op_a %0h, expected none", op_a);
        end else begin
          w = want_q.pop_front();
          chk("op_a", op_a, w.a);
          chk("op_b", op_b, w.b);
          chk("op_rd", 64'(op_rd), 64'(w.rd));
          chk("op_wr", 64'(op_wr), 64'(w.wr));
          chk("op_ctrl", 64'(op_ctrl), 64'(w.ctrl));
          chk("op_valid_cycle", 64'(first_cyc), 64'(w.vcyc));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w_cyc, h_cyc, n_byp_adj;
    reset_n = 1'b0; issue_valid = 1'b0; issue_rs0 = '0; issue_rs1 = '0; issue_use = '0;
    issue_rd = '0; issue_wr = 1'b0; issue_ctrl = '0; wb_valid = 1'b0; wb_addr = '0;
    wb_data = '0; op_ready = 1'b0;
`ifdef OPERAND_COLLECTOR_WB_BYPASS_EN
    n_byp_adj = 1;
`else
    n_byp_adj = 0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_busy", 64'(busy_pending), 64'h0);
    chk("rst_rf_read_en", 64'(rf_read_en), 64'd0);
    chk("rst_op_a", op_a, 64'h0);
    chk("rst_raddr0", 64'(rf_raddr_0), 64'd0);

    // Preload R3/R5; writeback to non-pending registers leaves the scoreboard untouched.
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 64'hDEAD_BEEF;
    @(negedge clk);
    wb_addr = 4'd5; wb_data = 64'h1234;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("wb_nonpending_busy", 64'(busy_pending), 64'h0);

    // Basic two-source read, op_valid at T+3.
    op_ready = 1'b1;
    do_issue(4'd3, 4'd5, 2'b11, 4'd9, 1'b0, 8'h5A, t);
    push_want(64'hDEAD_BEEF, 64'h1234, 4'd9, 1'b0, 8'h5A, t + 3);
    chk("basic_rf_read_en", 64'(rf_read_en), 64'd3);
    chk("basic_raddr0", 64'(rf_raddr_0), 64'd3);
    chk("basic_raddr1", 64'(rf_raddr_1), 64'd5);
    wait_drain();

    // Writer to R7, then a reader of R7 stalls until writeback.
    do_issue(4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 8'h01, t);
    push_want(64'h0, 64'h0, 4'd7, 1'b1, 8'h01, t + 3);
    wait_drain();
    chk("writer_busy", 64'(busy_pending), 64'h0080);
    do_issue(4'd7, 4'd0, 2'b01, 4'd8, 1'b0, 8'h02, t);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rf_read_en", 64'(rf_read_en), 64'd0);
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 64'hAA;
    w_cyc = cyc;
    push_want(64'hAA, 64'h0, 4'd8, 1'b0, 8'h02, w_cyc + 3 - n_byp_adj);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("wb_clear_busy", 64'(busy_pending), 64'h0);
    chk("post_wb_rf_read_en", 64'(rf_read_en), (n_byp_adj == 1) ? 64'd0 : 64'd1);
    wait_drain();

    // Backpressure in HOLD; a waiting issue is only accepted after the handshake.
    op_ready = 1'b0;
    do_issue(4'd5, 4'd3, 2'b11, 4'd4, 1'b1, 8'hC3, t);
    push_want(64'h1234, 64'hDEAD_BEEF, 4'd4, 1'b1, 8'hC3, t + 3);
    repeat (2) @(negedge clk);
    issue_valid = 1'b1; issue_rs0 = 4'hF; issue_rs1 = 4'hE; issue_use = 2'b00;
    issue_rd = 4'd2; issue_wr = 1'b1; issue_ctrl = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("hold_op_valid", 64'(op_valid), 64'd1);
      chk("hold_op_a", op_a, 64'h1234);
      chk("hold_op_b", op_b, 64'hDEAD_BEEF);
      chk("hold_issue_ready", 64'(issue_ready), 64'd0);
      @(negedge clk);
    end
    op_ready = 1'b1;
    h_cyc = cyc;
    do_issue(4'hF, 4'hE, 2'b00, 4'd2, 1'b1, 8'h77, t);
    chk("accept_after_hs", 64'(t), 64'(h_cyc + 1));
    push_want(64'h0, 64'h0, 4'd2, 1'b1, 8'h77, t + 3);
    // No sources used: no RF reads, operands zero despite stale read data.
    chk("nouse_rf_read_en_chk", 64'(rf_read_en), 64'd0);
    @(negedge clk);
    chk("nouse_rf_read_en_rd", 64'(rf_read_en), 64'd0);
    @(negedge clk);
    // Dispatch of writer to R2 coincides with writeback to R2: set wins.
    wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 64'h55;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("set_wins_busy", 64'(busy_pending), 64'h0014);
    wait_drain();

    // Reset while holding a valid result.
    op_ready = 1'b0;
    do_issue(4'd3, 4'd0, 2'b01, 4'hA, 1'b1, 8'h11, t);
    repeat (2) @(negedge clk);
    chk("pre_rst_op_valid", 64'(op_valid), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("in_rst_op_valid", 64'(op_valid), 64'd0);
    chk("in_rst_busy", 64'(busy_pending), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("post_rst_op_valid", 64'(op_valid), 64'd0);
    chk("post_rst_busy", 64'(busy_pending), 64'h0);
    chk("post_rst_op_a", op_a, 64'h0);
    chk("post_rst_op_wr", 64'(op_wr), 64'd0);

    // Operation resumes after reset: only rs1 used.
    op_ready = 1'b1;
    do_issue(4'd3, 4'd5, 2'b10, 4'd1, 1'b0, 8'hD0, t);
    push_want(64'h0, 64'h1234, 4'd1, 1'b0, 8'hD0, t + 3);
    chk("rs1_only_rf_read_en", 64'(rf_read_en), 64'd2);
    wait_drain();

    chk("queue_empty", 64'(want_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
